// File: rtl/dlyb_tap_ctrl.sv
// dlyb_tap_ctrl
// Tap-select sequencer for a delay line built from chained delay-buffer cells
// feeding a tap mux. TAP_SEL only ever moves one step at a time and every step
// is followed by a settle window, so the mux output never glitches.
// Serves manual tap moves (valid/ready) and a calibration sweep that finds
// the longest tap whose delay stays under one clock period.
//
// Ports
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   CAL_START  one-cycle calibration request (accepted in IDLE only)
//   REQ_VLD    manual tap request valid
//   REQ_TAP    requested tap, sampled on REQ_VLD & REQ_RDY
//   REQ_RDY    ready for a manual request (IDLE and no CAL_START)
//   SAMPLE     delay-line output at TAP_SEL, captured externally on CLK
//   TAP_SEL    registered tap select to the mux
//   LAUNCH     registered toggle driven into the delay-line input
//   BUSY       high in any state other than IDLE
//   DONE       one-cycle pulse at the end of a move or calibration
//   LOCKED     last calibration succeeded
//   CAL_FAIL   last calibration failed
//   CAL_TAP    result of the last successful calibration
module dlyb_tap_ctrl #(
  parameter int unsigned NTAP_W = 5,
  parameter int unsigned SETTLE = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CAL_START,
  input  logic              REQ_VLD,
  input  logic [NTAP_W-1:0] REQ_TAP,
  output logic              REQ_RDY,
  input  logic              SAMPLE,
  output logic [NTAP_W-1:0] TAP_SEL,
  output logic              LAUNCH,
  output logic              BUSY,
  output logic              DONE,
  output logic              LOCKED,
  output logic              CAL_FAIL,
  output logic [NTAP_W-1:0] CAL_TAP
);

  localparam int unsigned      CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [NTAP_W-1:0] TAP_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_LD  = CNT_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_SETTLE, S_LNCH, S_WAIT1, S_WAIT2, S_EVAL, S_FIN
  } state_t;

  // What the MOVE/SETTLE loop is currently serving.
  typedef enum logic [1:0] {
    PH_MAN, PH_DESC, PH_SWEEP, PH_RET
  } phase_t;

  state_t            state, state_n;
  phase_t            phase, phase_n;
  logic [NTAP_W-1:0] target, target_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [NTAP_W-1:0] tap_n, cal_tap_n;
  logic              launch_n, busy_n, done_n, locked_n, cal_fail_n;

  assign REQ_RDY = (state == S_IDLE) && !CAL_START;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      phase    <= PH_MAN;
      target   <= '0;
      cnt      <= '0;
      TAP_SEL  <= '0;
      LAUNCH   <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      LOCKED   <= 1'b0;
      CAL_FAIL <= 1'b0;
      CAL_TAP  <= '0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      target   <= target_n;
      cnt      <= cnt_n;
      TAP_SEL  <= tap_n;
      LAUNCH   <= launch_n;
      BUSY     <= busy_n;
      DONE     <= done_n;
      LOCKED   <= locked_n;
      CAL_FAIL <= cal_fail_n;
      CAL_TAP  <= cal_tap_n;
    end
  end

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    target_n   = target;
    cnt_n      = cnt;
    tap_n      = TAP_SEL;
    launch_n   = LAUNCH;
    locked_n   = LOCKED;
    cal_fail_n = CAL_FAIL;
    cal_tap_n  = CAL_TAP;

    unique case (state)
      S_IDLE: begin
        if (CAL_START) begin
          // Calibration first descends to tap 0 through the normal move loop.
          phase_n    = PH_DESC;
          target_n   = '0;
          locked_n   = 1'b0;
          cal_fail_n = 1'b0;
          state_n    = S_MOVE;
        end else if (REQ_VLD) begin
          phase_n  = PH_MAN;
          target_n = REQ_TAP;
          state_n  = (REQ_TAP == TAP_SEL) ? S_FIN : S_MOVE;
        end
      end

      // MOVE either takes one step toward target or, when already there,
      // hands over to whatever the current phase does next.
      S_MOVE: begin
        if (TAP_SEL == target) begin
          unique case (phase)
            PH_MAN:  state_n = S_FIN;
            PH_RET: begin
              locked_n  = 1'b1;
              cal_tap_n = target;
              state_n   = S_FIN;
            end
            default: begin
              phase_n = PH_SWEEP;
              state_n = S_LNCH;
            end
          endcase
        end else begin
          tap_n   = (target > TAP_SEL) ? TAP_SEL + 1'b1 : TAP_SEL - 1'b1;
          cnt_n   = CNT_LD;
          state_n = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = (phase == PH_SWEEP) ? S_LNCH : S_MOVE;
        end
      end

      S_LNCH: begin
        launch_n = ~LAUNCH;
        state_n  = S_WAIT1;
      end

      S_WAIT1: state_n = S_WAIT2;
      S_WAIT2: state_n = S_EVAL;

      S_EVAL: begin
        if (SAMPLE == LAUNCH) begin
          if (TAP_SEL == TAP_MAX) begin
            cal_fail_n = 1'b1;
            state_n    = S_FIN;
          end else begin
            target_n = TAP_SEL + 1'b1;
            state_n  = S_MOVE;
          end
        end else if (TAP_SEL == '0) begin
          cal_fail_n = 1'b1;
          state_n    = S_FIN;
        end else begin
          // Back off one tap; result is committed when FIN is entered.
          target_n = TAP_SEL - 1'b1;
          phase_n  = PH_RET;
          state_n  = S_MOVE;
        end
      end

      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    done_n = (state_n == S_FIN);
    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: doc/dlyb_tap_ctrl.md
# dlyb_tap_ctrl

Sequencer for a tapped delay line built from chained 7-track delay-buffer cells feeding a one-hot/binary tap mux. It moves the tap select one step at a time, never jumping, so the mux output stays glitch-free. It runs a calibration sweep that finds the longest tap whose delay stays under one clock period. It also serves manual tap-change requests through a valid/ready handshake.

## Interface
- NTAP_W, 5: width of tap select; taps 0 .. 2^NTAP_W-1.
- SETTLE, 4: cycles held after every tap change before anything else happens (≥1).

- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- CAL_START  in  1  one-cycle calibration request; accepted only in IDLE.
- REQ_VLD  in  1  manual tap request valid.
- REQ_TAP  in  NTAP_W  requested tap; sampled when REQ_VLD & REQ_RDY.
- REQ_RDY  out  1  high only in IDLE with CAL_START low.
- SAMPLE  in  1  external capture flop output: delay-line output at TAP_SEL, captured on CLK.
- TAP_SEL  out  NTAP_W  registered tap select to the mux.
- LAUNCH  out  1  registered toggle driven into delay-line input.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse at the end of a manual move or a calibration.
- LOCKED  out  1  last calibration succeeded; cleared at CAL_START acceptance.
- CAL_FAIL  out  1  last calibration failed; cleared at CAL_START acceptance.
- CAL_TAP  out  NTAP_W  result of last successful calibration.

## Operation
- Reset values: TAP_SEL=0, LAUNCH=0, BUSY=0, DONE=0, LOCKED=0, CAL_FAIL=0, CAL_TAP=0. State is IDLE and the settle counter is 0.
- States: IDLE, MOVE, SETTLE, LNCH, WAIT1, WAIT2, EVAL, FIN.
- TAP_SEL changes only by +1 or −1 per change, and each change is always followed by SETTLE full cycles in SETTLE state.
- Priority in IDLE: CAL_START wins over REQ_VLD in the same cycle. REQ_RDY is 0 that cycle, so the request is not accepted.
- Manual move:
  - Accept at a REQ_VLD&REQ_RDY handshake and latch the target.
  - If target == TAP_SEL, go to FIN directly.
  - Otherwise MOVE steps TAP_SEL toward the target, then SETTLE. Repeat until equal, then FIN.
  - LAUNCH is untouched.
- Calibration, phase 1 (descent): step TAP_SEL down to 0 as in a manual move.
- Calibration, phase 2 (sweep), per tap t:
  - SETTLE.
  - LNCH toggles LAUNCH.
  - WAIT1 and WAIT2 allow capture.
  - EVAL compares SAMPLE with LAUNCH.
  - If SAMPLE == LAUNCH, the delay is under one period. If t < max, TAP_SEL = t+1 and go to SETTLE. If t == max, fail.
  - If SAMPLE != LAUNCH and t == 0, fail.
  - If SAMPLE != LAUNCH and t > 0, CAL_TAP = t−1 and TAP_SEL steps to t−1, then SETTLE, then FIN with LOCKED=1.
- Fail handling:
  - CAL_FAIL=1 and CAL_TAP unchanged.
  - TAP_SEL stays where it is: 0 for a t==0 fail, max for a t==max fail.
  - Then FIN.
- FIN: DONE=1 for one cycle, then return to IDLE.
- CAL_START and REQ_VLD are ignored while BUSY. A held REQ_VLD is accepted on the first IDLE cycle.
- RST mid-operation: immediate return to reset values, including TAP_SEL=0. The resulting jump is accepted; no DONE pulse.

## Timing
- All outputs are registered and change only on the rising edge of CLK.
- REQ_RDY is combinational from state and CAL_START.
- Manual move by d≠0 taps: handshake at edge 0, DONE high in cycle d·(SETTLE+1)+1, BUSY low the cycle after.
- Move with d=0: DONE in the cycle after acceptance.
- Sweep cost per tap: SETTLE + 4 cycles (LNCH, WAIT1, WAIT2, EVAL), plus one MOVE cycle per increment.
- SAMPLE is evaluated in EVAL, i.e. it is the value registered two edges after LAUNCH toggled.
- LOCKED, CAL_FAIL and CAL_TAP update on the edge entering FIN and are stable while DONE is high.

## Test plan
- Reset/idle: assert RST for 3 cycles mid-sweep -> all outputs return to reset values on the next edge; REQ_RDY=1 afterward.
- Manual move (NTAP_W=3, SETTLE=2): TAP_SEL=0, REQ_TAP=5 -> TAP_SEL steps 1,2,3,4,5, each held 3 cycles; DONE in cycle 16; no multi-step jumps.
- Calibration success: delay model with SAMPLE mismatching for t≥6, start tap 3 -> descends to 0, sweeps to 6, returns to 5; CAL_TAP=5, LOCKED=1, CAL_FAIL=0; DONE once.
- Calibration fail low: mismatch already at t=0 -> CAL_FAIL=1, LOCKED=0, TAP_SEL=0, CAL_TAP keeps its previous value.
- Calibration fail high: never mismatching, NTAP_W=3 -> sweeps to 7; CAL_FAIL=1, TAP_SEL=7.
- Arbitration: CAL_START and REQ_VLD together in IDLE -> calibration runs, request not accepted until BUSY drops; then request accepted and move completes with its own DONE.
